// File: rtl/sd_pkg.sv
// Shared constants and state type for the SD block-transfer responder.
package sd_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_AW    = 9;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRdXfer,
    StWrXfer,
    StDone
  } sd_resp_state_t;

endpackage

// File: rtl/sd_block_responder.sv
// HPS-side stand-in for the hps_io SD block protocol: answers sd_rd/sd_wr by
// streaming one 512-byte sector between an external byte store and the core's
// sector buffer, one byte per cycle, with a two-stage issue/complete pipeline.
module sd_block_responder
  import sd_pkg::*;
#(
  parameter int unsigned MEM_AW      = 16,
  parameter int unsigned ACK_LATENCY = 4
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              lba_err
);

  localparam int unsigned LbaW       = MEM_AW - SECTOR_AW;
  localparam logic [32:0] NumSectors = 33'(1) << LbaW;

  sd_resp_state_t         state_q;
  logic [7:0]             cnt_q;
  logic [LbaW-1:0]        lba_q;
  logic                   wr_dir_q;
  logic [SECTOR_AW:0]     idx_q;       // next byte to issue; MSB set once all 512 are issued
  logic                   pend_q;      // a byte issued last cycle completes this cycle
  logic [SECTOR_AW-1:0]   pend_idx_q;

  logic                   req;
  logic                   acc_err;
  logic                   start;
  logic                   issue;
  logic [SECTOR_AW-1:0]   issue_idx;
  logic                   issue_wr;
  logic                   issue_err;
  logic [LbaW-1:0]        issue_lba;

  // Both data paths forward the registered RAM outputs in the strobe cycle.
  assign sd_buff_dout = (sd_buff_wr && !lba_err) ? mem_rdata : 8'h00;
  assign mem_wdata    = mem_we ? sd_buff_din : 8'h00;

  // Decide whether a byte is issued this cycle; with zero latency the first
  // byte is issued straight from IDLE using the live request fields.
  always_comb begin
    req       = sd_rd | sd_wr;
    acc_err   = {1'b0, sd_lba} >= NumSectors;
    start     = ((state_q == StIdle) && req && (ACK_LATENCY == 0)) ||
                ((state_q == StWait) && (cnt_q == '0));
    issue     = start ||
                (((state_q == StRdXfer) || (state_q == StWrXfer)) && !idx_q[SECTOR_AW]);
    issue_idx = start ? '0 : idx_q[SECTOR_AW-1:0];
    issue_wr  = (state_q == StIdle) ? sd_wr : wr_dir_q;
    issue_err = (state_q == StIdle) ? acc_err : lba_err;
    issue_lba = (state_q == StIdle) ? sd_lba[LbaW-1:0] : lba_q;
  end

  // Request FSM plus the issue (stage 1) and complete (stage 2) byte pipeline.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      lba_q        <= '0;
      wr_dir_q     <= 1'b0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      pend_idx_q   <= '0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      lba_err      <= 1'b0;
    end else begin
      sd_buff_wr <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      pend_q     <= issue;
      pend_idx_q <= issue_idx;

      if (issue) begin
        idx_q <= {1'b0, issue_idx} + (SECTOR_AW + 1)'(1);
        if (issue_wr) begin
          sd_buff_addr <= issue_idx;
        end else begin
          mem_re   <= !issue_err;
          mem_addr <= {issue_lba, issue_idx};
        end
      end

      if (pend_q) begin
        if (wr_dir_q) begin
          mem_we   <= !lba_err;
          mem_addr <= {lba_q, pend_idx_q};
        end else begin
          sd_buff_wr   <= 1'b1;
          sd_buff_addr <= pend_idx_q;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (req) begin
            wr_dir_q <= sd_wr;
            lba_q    <= sd_lba[LbaW-1:0];
            lba_err  <= acc_err;
            sd_ack   <= 1'b1;
            if (ACK_LATENCY == 0) begin
              state_q <= sd_wr ? StWrXfer : StRdXfer;
            end else begin
              state_q <= StWait;
              cnt_q   <= 8'(ACK_LATENCY - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= wr_dir_q ? StWrXfer : StRdXfer;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StRdXfer, StWrXfer: begin
          // Leave once the last byte has been issued and completed.
          if (idx_q[SECTOR_AW] && !pend_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          sd_ack <= 1'b0;
          // Hold here while the request is still up so it is not served twice.
          if (!req) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder: behavioural store and sector
// buffer around the DUT, a per-cycle timing/data model, and directed tests.
module tb_sd_block_responder;

  localparam int unsigned MEM_AW = 12;
  localparam int unsigned LAT    = 4;
  localparam int          NSEC   = 8;
  localparam int          MEMSZ  = 4096;

  logic              clk_100m = 1'b0;
  logic              rst_n    = 1'b0;
  logic [31:0]       sd_lba   = '0;
  logic              sd_rd    = 1'b0;
  logic              sd_wr    = 1'b0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din = '0;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_rdata = '0;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              lba_err;

  sd_block_responder #(
    .MEM_AW      (MEM_AW),
    .ACK_LATENCY (LAT)
  ) dut (
    .clk_100m     (clk_100m),
    .rst_n        (rst_n),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .lba_err      (lba_err)
  );

  initial forever #5 clk_100m = ~clk_100m;

  int total = 0;
  int bad   = 0;
  int cmd   = 0;   // 1: init store, 2: fill buffer A5^k, 3: clear buffer

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Environment: registered-read byte store and sector buffer.
  logic [7:0] env_mem [MEMSZ];
  logic [7:0] env_buf [512];

  always @(posedge clk_100m) begin
    if (cmd == 1) for (int a = 0; a < MEMSZ; a++) env_mem[a] <= 8'(a) ^ 8'(a >> 9);
    if (cmd == 2) for (int k = 0; k < 512; k++) env_buf[k] <= 8'hA5 ^ 8'(k);
    if (cmd == 3) for (int k = 0; k < 512; k++) env_buf[k] <= 8'h00;
    if (mem_re) mem_rdata <= env_mem[mem_addr];
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    if (sd_buff_wr) env_buf[sd_buff_addr] <= sd_buff_dout;
    sd_buff_din <= env_buf[sd_buff_addr];
  end

  // Reference model: transaction accepted at cycle T occupies a fixed window.
  logic [7:0] ref_mem [MEMSZ];
  logic [7:0] ref_buf [512];
  int   cyc = 0, t_acc = 0, o = 0, base = 0;
  bit   armed = 0, act = 0, idle = 1, m_wr = 0, m_err = 0;
  int   m_lba = 0;
  bit   e_ack, e_re, e_we, e_bwr, prev_ack = 0;
  logic [7:0] ed;
  int   cnt_bwr = 0, cnt_re = 0, cnt_we = 0, cnt_ackhi = 0, cnt_rise = 0;

  initial forever begin
    @(negedge clk_100m);
    if (armed) begin
      e_ack = 0; e_re = 0; e_we = 0; e_bwr = 0;
      o     = cyc - t_acc - 1 - int'(LAT);
      base  = (m_lba % NSEC) * 512;
      if (act) begin
        e_ack = (cyc >= t_acc + 1) && (cyc <= t_acc + int'(LAT) + 514);
        if (!m_wr) begin
          e_re  = !m_err && o >= 0 && o < 512;
          e_bwr = o >= 1 && o <= 512;
        end else begin
          e_we  = !m_err && o >= 1 && o <= 512;
        end
      end
      chk("sd_ack", 32'(sd_ack), 32'(e_ack));
      chk("mem_re", 32'(mem_re), 32'(e_re));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("sd_buff_wr", 32'(sd_buff_wr), 32'(e_bwr));
      chk("lba_err", 32'(lba_err), 32'(m_err));
      if (e_re) chk("rd_mem_addr", 32'(mem_addr), 32'(base + o));
      if (e_bwr) begin
        ed = m_err ? 8'h00 : ref_mem[base + o - 1];
        chk("rd_buff_addr", 32'(sd_buff_addr), 32'(o - 1));
        chk("rd_buff_dout", 32'(sd_buff_dout), 32'(ed));
        ref_buf[o - 1] = ed;
      end
      if (act && m_wr && o >= 0 && o < 512) chk("wr_buff_addr", 32'(sd_buff_addr), 32'(o));
      if (e_we) begin
        chk("wr_mem_addr", 32'(mem_addr), 32'(base + o - 1));
        chk("wr_mem_wdata", 32'(mem_wdata), 32'(ref_buf[o - 1]));
        ref_mem[base + o - 1] = ref_buf[o - 1];
      end
      cnt_bwr   += int'(sd_buff_wr);
      cnt_re    += int'(mem_re);
      cnt_we    += int'(mem_we);
      cnt_ackhi += int'(sd_ack);
      if (sd_ack && !prev_ack) cnt_rise++;
      prev_ack = sd_ack;
    end
    if (cmd == 1) for (int a = 0; a < MEMSZ; a++) ref_mem[a] = 8'(a) ^ 8'(a >> 9);
    if (cmd == 2) for (int k = 0; k < 512; k++) ref_buf[k] = 8'hA5 ^ 8'(k);
    if (cmd == 3) for (int k = 0; k < 512; k++) ref_buf[k] = 8'h00;
    // State seen at the coming edge, from this cycle's inputs.
    if (!rst_n) begin
      armed = 1; act = 0; idle = 1; m_err = 0;
    end else if (armed) begin
      if (idle && (sd_rd || sd_wr)) begin
        idle = 0; act = 1; t_acc = cyc; m_wr = sd_wr;
        m_lba = int'(sd_lba & 32'h7FFF_FFFF);
        m_err = sd_lba >= 32'(NSEC);
      end else if (!idle && cyc >= t_acc + int'(LAT) + 514 && !sd_rd && !sd_wr) begin
        idle = 1; act = 0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic do_cmd(input int c);
    cmd = c;
    step();
    cmd = 0;
  endtask

  task automatic wait_ack(input bit level, input int limit);
    int n = 0;
    while (sd_ack !== level && n < limit) begin
      step();
      n++;
    end
    chk(level ? "ack_rise_timeout" : "ack_fall_timeout", 32'(sd_ack), 32'(level));
  endtask

  // Raise a request until acknowledged, drop it, then wait for completion.
  task automatic xfer(input bit rd, input bit wr, input int lba);
    sd_rd = rd; sd_wr = wr; sd_lba = 32'(lba);
    wait_ack(1'b1, 20);
    sd_rd = 0; sd_wr = 0;
    wait_ack(1'b0, 700);
    step();
    step();
  endtask

  int b0, b1, nerr, n;

  initial begin
    repeat (3) step();
    chk("rst_sd_ack", 32'(sd_ack), 0);
    chk("rst_sd_buff_wr", 32'(sd_buff_wr), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_lba_err", 32'(lba_err), 0);
    chk("rst_sd_buff_addr", 32'(sd_buff_addr), 0);
    chk("rst_sd_buff_dout", 32'(sd_buff_dout), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    do_cmd(1);
    rst_n = 1;
    step();

    // Read sector 3: buffer gets k^3.
    b0 = cnt_bwr; b1 = cnt_ackhi;
    xfer(1, 0, 3);
    chk("rd3_buff_wr_count", 32'(cnt_bwr - b0), 512);
    chk("rd3_ack_cycles", 32'(cnt_ackhi - b1), 32'(LAT + 514));
    nerr = 0;
    for (int k = 0; k < 512; k++) if (env_buf[k] !== (8'(k) ^ 8'h03)) nerr++;
    chk("rd3_buffer_errors", 32'(nerr), 0);
    chk("rd3_byte0", 32'(env_buf[0]), 32'h03);
    chk("rd3_byte511", 32'(env_buf[511]), 32'hFC);

    // Write sector 7 from A5^k, read it back into a cleared buffer.
    do_cmd(2);
    b0 = cnt_we;
    xfer(0, 1, 7);
    chk("wr7_mem_we_count", 32'(cnt_we - b0), 512);
    chk("wr7_store_byte0", 32'(env_mem[7 * 512]), 32'hA5);
    chk("wr7_store_byte511", 32'(env_mem[7 * 512 + 511]), 32'h5A);
    do_cmd(3);
    xfer(1, 0, 7);
    nerr = 0;
    for (int k = 0; k < 512; k++) if (env_buf[k] !== (8'hA5 ^ 8'(k))) nerr++;
    chk("rb7_buffer_errors", 32'(nerr), 0);
    chk("rb7_byte16", 32'(env_buf[16]), 32'hB5);

    // Both requests high: write wins, no store reads.
    b0 = cnt_re; b1 = cnt_we;
    xfer(1, 1, 2);
    chk("both_mem_re_count", 32'(cnt_re - b0), 0);
    chk("both_mem_we_count", 32'(cnt_we - b1), 512);
    chk("both_store_byte3", 32'(env_mem[2 * 512 + 3]), 32'hA6);

    // Out-of-range sector 8 with 8 sectors of capacity.
    xfer(1, 0, 8);
    chk("oor_rd_lba_err", 32'(lba_err), 1);
    nerr = 0;
    for (int k = 0; k < 512; k++) if (env_buf[k] !== 8'h00) nerr++;
    chk("oor_rd_buffer_nonzero", 32'(nerr), 0);
    do_cmd(2);
    b0 = cnt_we;
    xfer(0, 1, 8);
    chk("oor_wr_mem_we_count", 32'(cnt_we - b0), 0);
    chk("oor_wr_store_byte5", 32'(env_mem[5]), 32'h05);
    chk("oor_wr_lba_err", 32'(lba_err), 1);
    xfer(1, 0, 1);
    chk("lba1_lba_err_clear", 32'(lba_err), 0);
    chk("lba1_byte300", 32'(env_buf[300]), 32'h2D);

    // Held request is served once; a fresh request after the drop is served.
    b0 = cnt_rise;
    sd_rd = 1; sd_lba = 32'd3;
    wait_ack(1'b1, 20);
    wait_ack(1'b0, 700);
    repeat (30) step();
    chk("held_single_transfer", 32'(cnt_rise - b0), 1);
    sd_rd = 0;
    repeat (3) step();
    xfer(1, 0, 3);
    chk("held_second_transfer", 32'(cnt_rise - b0), 2);

    // Reset at byte 100 of a read.
    sd_rd = 1; sd_lba = 32'd5;
    wait_ack(1'b1, 20);
    sd_rd = 0;
    n = 0;
    while (!(sd_buff_wr === 1'b1 && sd_buff_addr === 9'd100) && n < 200) begin
      step();
      n++;
    end
    chk("mid_reached_byte100", 32'(sd_buff_addr), 100);
    rst_n = 0;
    step();
    chk("mid_rst_ack", 32'(sd_ack), 0);
    chk("mid_rst_buff_wr", 32'(sd_buff_wr), 0);
    rst_n = 1;
    b0 = cnt_bwr + cnt_re + cnt_we; b1 = cnt_rise;
    repeat (600) step();
    chk("mid_rst_no_strobes", 32'(cnt_bwr + cnt_re + cnt_we - b0), 0);
    chk("mid_rst_no_ack", 32'(cnt_rise - b1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
